// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexed 8-bit QIF neuron array: one neuron updated per clk while RUN, step_done
// pulses N_NEURONS+1 cycles after the start edge; no backpressure, i_syn must be valid in the cycle it is indexed.
module qif_neuron_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int IDX_W     = 3,
  parameter int V_PEAK    = 50,
  parameter int V_RESET   = -20,
  parameter int REFRAC    = 2,
  parameter int REFRAC_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_start,
  input  logic                clear,
  output logic [IDX_W-1:0]    syn_idx,
  input  logic signed [7:0]   i_syn,
  output logic                busy,
  output logic                step_done,
  output logic                spike_valid,
  output logic [IDX_W-1:0]    spike_idx,
  output logic [7:0]          spike_count,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic signed [7:0]   rd_vmem
);

  localparam logic signed [7:0]  V_PEAK_C  = 8'(V_PEAK);
  localparam logic signed [7:0]  V_RESET_C = 8'(V_RESET);
  localparam logic [REFRAC_W-1:0] REFRAC_C = REFRAC_W'(REFRAC);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   state_q;
  logic [IDX_W-1:0]         cnt_q;
  logic [7:0]               tally_q;
  logic signed [7:0]        v_q   [N_NEURONS];
  logic [REFRAC_W-1:0]      ref_q [N_NEURONS];
  logic                     busy_q, done_q, spk_vld_q;
  logic [IDX_W-1:0]         spk_idx_q;
  logic [7:0]               spk_cnt_q;

  logic signed [7:0]        v_cur;
  logic [REFRAC_W-1:0]      ref_cur;
  logic signed [11:0]       v_ext, i_ext, v_div8, i_div4, sq, sum;
  logic signed [7:0]        v_sat;
  logic signed [7:0]        v_d;
  logic [REFRAC_W-1:0]      ref_d;
  logic                     spike_d;

  assign v_cur   = v_q[cnt_q];
  assign ref_cur = ref_q[cnt_q];

  // Biasing negatives before the arithmetic shift gives truncation toward zero.
  always_comb begin
    v_ext  = {{4{v_cur[7]}}, v_cur};
    i_ext  = {{4{i_syn[7]}}, i_syn};
    v_div8 = (v_ext + (v_cur[7] ? 12'sd7 : 12'sd0)) >>> 3;
    i_div4 = (i_ext + (i_syn[7] ? 12'sd3 : 12'sd0)) >>> 2;
    sq     = v_div8 * v_div8;
    sum    = v_ext + i_div4 + sq;
    if (sum > 12'sd127)
      v_sat = 8'sd127;
    else if (sum < -12'sd128)
      v_sat = -8'sd128;
    else
      v_sat = sum[7:0];
  end

  always_comb begin
    v_d     = v_cur;
    ref_d   = ref_cur;
    spike_d = 1'b0;
    if (ref_cur != '0) begin
      ref_d = ref_cur - REFRAC_W'(1);
    end else if (v_cur >= V_PEAK_C) begin
      v_d     = V_RESET_C;
      ref_d   = REFRAC_C;
      spike_d = 1'b1;
    end else begin
      v_d = v_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tally_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      spk_vld_q <= 1'b0;
      spk_idx_q <= '0;
      spk_cnt_q <= '0;
      for (int j = 0; j < N_NEURONS; j++) begin
        v_q[j]   <= '0;
        ref_q[j] <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      spk_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clear) begin
            for (int j = 0; j < N_NEURONS; j++) begin
              v_q[j]   <= '0;
              ref_q[j] <= '0;
            end
          end else if (step_start) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            tally_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          v_q[cnt_q]   <= v_d;
          ref_q[cnt_q] <= ref_d;
          tally_q      <= tally_q + 8'(spike_d);
          if (spike_d) begin
            spk_vld_q <= 1'b1;
            spk_idx_q <= cnt_q;
          end
          if (cnt_q == LAST_IDX) begin
            state_q <= S_DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          done_q    <= 1'b1;
          spk_cnt_q <= tally_q;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign syn_idx     = cnt_q;
  assign busy        = busy_q;
  assign step_done   = done_q;
  assign spike_valid = spk_vld_q;
  assign spike_idx   = spk_idx_q;
  assign spike_count = spk_cnt_q;
  assign rd_vmem     = v_q[rd_idx];

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Bench for qif_neuron_scheduler: vector table for the neuron-0 trajectory, spike scoreboard,
// and directed sequences for control corners and asynchronous reset.
`timescale 1ns/100ps
module tb_qif_neuron_scheduler;
  localparam int N = 8;

  logic                clk;
  logic                rst_n;
  logic                step_start;
  logic                clear;
  logic [2:0]          syn_idx;
  logic signed [7:0]   i_syn;
  logic                busy;
  logic                step_done;
  logic                spike_valid;
  logic [2:0]          spike_idx;
  logic [7:0]          spike_count;
  logic [2:0]          rd_idx;
  logic signed [7:0]   rd_vmem;

  logic signed [7:0]   cur_tab [N];
  int                  mv   [N];
  int                  mref [N];
  int                  checks;
  int                  errors;
  int                  cyc;
  int                  done_seen;
  int                  steps_run;

  typedef struct {int idx; int cyc;} spk_t;
  spk_t spk_q[$];

  typedef struct {logic signed [7:0] cur0; int exp_v0; int exp_cnt;} vec_t;
  vec_t tbl [8];

  qif_neuron_scheduler #(
    .N_NEURONS(8), .IDX_W(3), .V_PEAK(50), .V_RESET(-20), .REFRAC(2), .REFRAC_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_start(step_start), .clear(clear),
    .syn_idx(syn_idx), .i_syn(i_syn), .busy(busy), .step_done(step_done),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_count(spike_count),
    .rd_idx(rd_idx), .rd_vmem(rd_vmem)
  );

  assign i_syn = cur_tab[syn_idx];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (step_done) done_seen++;
      if (spike_valid) begin
        if (spk_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spike_unexpected: idx %0d at cycle %0d, expected no spike", spike_idx, cyc);
        end else begin
          spk_t e;
          e = spk_q.pop_front();
          chk("spike_idx", spike_idx, e.idx);
          chk("spike_cycle", cyc, e.cyc);
        end
      end
    end
  end

  function automatic int qif(input int v, input int i);
    int t;
    t = v + i / 4 + (v / 8) * (v / 8);
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t;
  endfunction

  task automatic model_step(input int c0, output int cnt);
    cnt = 0;
    for (int j = 0; j < N; j++) begin
      if (mref[j] > 0) begin
        mref[j]--;
      end else if (mv[j] >= 50) begin
        mv[j]   = -20;
        mref[j] = 2;
        cnt++;
        spk_q.push_back('{j, c0 + 2 + j});
      end else begin
        mv[j] = qif(mv[j], int'(cur_tab[j]));
      end
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < N; j++) begin
      mv[j]   = 0;
      mref[j] = 0;
    end
  endtask

  task automatic chk_all(input string tag);
    for (int j = 0; j < N; j++) begin
      rd_idx = 3'(j);
      #1;
      chk($sformatf("%s_vmem%0d", tag, j), rd_vmem, mv[j]);
    end
  endtask

  // Called at #1 after a rising edge; the start is sampled on the next edge.
  task automatic run_step(input bit hold, input bit clr_mid);
    int n;
    int exp_cnt;
    model_step(cyc, exp_cnt);
    step_start = 1'b1;
    @(posedge clk); #1;
    if (!hold) step_start = 1'b0;
    chk("busy_run", busy, 1);
    n = 0;
    while (!step_done && n < 20) begin
      clear = (clr_mid && n == 3);
      @(posedge clk); #1;
      n++;
    end
    clear      = 1'b0;
    step_start = 1'b0;
    chk("done_latency", n, N + 1);
    chk("busy_at_done", busy, 0);
    chk("spike_count", spike_count, exp_cnt);
    chk("spike_missing", spk_q.size(), 0);
    @(posedge clk); #1;
    chk("done_width", step_done, 0);
    chk("busy_idle", busy, 0);
    steps_run++;
    chk("done_count", done_seen, steps_run);
    chk_all("step");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; done_seen = 0; steps_run = 0;
    rst_n = 1'b0; step_start = 1'b0; clear = 1'b0; rd_idx = '0;
    for (int j = 0; j < N; j++) cur_tab[j] = '0;
    model_clear();

    tbl[0] = '{8'sd40,  10, 0};
    tbl[1] = '{8'sd40,  21, 0};
    tbl[2] = '{8'sd40,  35, 0};
    tbl[3] = '{8'sd40,  61, 0};
    tbl[4] = '{8'sd40, -20, 1};
    tbl[5] = '{8'sd40, -20, 0};
    tbl[6] = '{8'sd40, -20, 0};
    tbl[7] = '{8'sd40,  -6, 0};

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_spike_valid", spike_valid, 0);
    chk("rst_spike_idx", spike_idx, 0);
    chk("rst_spike_count", spike_count, 0);
    chk_all("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 3; s++) run_step(1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      cur_tab[0] = tbl[i].cur0;
      run_step(1'b0, 1'b0);
      rd_idx = 3'd0;
      #1;
      chk($sformatf("traj_v0_step%0d", i + 1), rd_vmem, tbl[i].exp_v0);
      chk($sformatf("traj_cnt_step%0d", i + 1), spike_count, tbl[i].exp_cnt);
    end

    run_step(1'b1, 1'b0);
    run_step(1'b0, 1'b1);

    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    chk_all("clear_idle");

    for (int j = 0; j < N; j++) cur_tab[j] = 8'sd4;
    run_step(1'b0, 1'b0);
    begin
      int d0;
      d0 = done_seen;
      clear = 1'b1;
      step_start = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      step_start = 1'b0;
      model_clear();
      chk("clr_start_busy", busy, 0);
      repeat (12) @(posedge clk);
      #1;
      chk("clr_start_no_done", done_seen, d0);
      chk_all("clr_start");
    end

    for (int j = 0; j < N; j++) cur_tab[j] = '0;
    cur_tab[1] = -8'sd36;
    run_step(1'b0, 1'b0);
    rd_idx = 3'd1; #1;
    chk("neg_preload_v1", rd_vmem, -9);
    cur_tab[1] = -8'sd3;
    run_step(1'b0, 1'b0);
    rd_idx = 3'd1; #1;
    chk("neg_trunc_v1", rd_vmem, -8);

    for (int j = 0; j < N; j++) cur_tab[j] = 8'sd20;
    @(posedge clk); #1;
    step_start = 1'b1;
    @(posedge clk); #1;
    step_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rd_idx = 3'd3; #1;
    chk("mid_run_v3", rd_vmem, qif(mv[3], 20));
    chk("mid_run_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("arst_busy", busy, 0);
    chk("arst_step_done", step_done, 0);
    chk("arst_spike_valid", spike_valid, 0);
    chk("arst_spike_idx", spike_idx, 0);
    chk("arst_spike_count", spike_count, 0);
    chk_all("arst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
